window_13x13_border_restorer: RTL and testbench
===============================================

# window_13x13_border_restorer

Sink-side companion to the 13x13 window buffer. It consumes the bursty, border-trimmed pixel stream the window pipeline produces: (COLS-12)x(ROWS-12) valid pulses with gaps at row ends. It re-emits a full COLS x ROWS raster, one pixel per cycle, with a constant pad value on the 6-pixel border. It sits between the window filter datapath and the frame writer, so downstream logic sees full-size frames.

## Interface
- DATA_WIDTH, 8, pixel width
- COLS, 640, frame width (>= 14)
- ROWS, 480, frame height (>= 14)
- PAD_VALUE, 0, value emitted on border pixels
- FIFO_DEPTH, 16, interior-pixel FIFO depth (power of two)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  frame-start pulse; accepted only in IDLE
- done_i  in  1  upstream interior pixel valid (no backpressure)
- data_i  in  DATA_WIDTH  upstream interior pixel
- data_o  out  DATA_WIDTH  output pixel, registered
- done_o  out  1  output pixel valid, registered
- progress_done  out  1  one-cycle pulse after last frame pixel
- overflow_o  out  1  sticky: done_i arrived with FIFO full

## Operation
- Reset: state IDLE, row/col counters 0, FIFO empty. Outputs: data_o=0, done_o=0, progress_done=0, overflow_o=0.
- FIFO push: on every done_i while not in IDLE/DONE/FINISH.
  - done_i with FIFO full: pixel dropped, overflow_o set.
  - done_i in IDLE: ignored.
- No FIFO bypass.
- Counters:
  - col range 0..COLS-1, width $clog2(COLS); row likewise for ROWS.
  - Advance only on cycles where an output pixel is issued.
  - col wraps to 0 at COLS-1 and increments row.
- Pixel class: border if row<6, row>=ROWS-6, col<6 or col>=COLS-6; otherwise interior.
- State machine:
  - IDLE: on start_i go to TOP; clear overflow_o and counters.
  - TOP: issue PAD every cycle. Go to ROW_L after issuing (row 5, col COLS-1).
  - ROW_L: issue PAD every cycle for cols 0..5, then go to ROW_M.
  - ROW_M: issue one FIFO pixel per cycle when FIFO non-empty; stall (no issue, counters hold) when empty. Go to ROW_R after issuing col COLS-7.
  - ROW_R: issue PAD for cols COLS-6..COLS-1. Next state is ROW_L, or BOT if the row just finished was ROWS-7.
  - BOT: issue PAD every cycle. Go to FINISH after issuing (ROWS-1, COLS-1).
  - FINISH: progress_done=1, then go to DONE.
  - DONE: go to IDLE next cycle.
- Issue in cycle t: data_o/done_o valid at t+1. done_o is 0 on non-issue cycles. data_o holds its last value when done_o=0.
- Any FIFO content left at FINISH is flushed (FIFO emptied).
- start_i outside IDLE is ignored.

## Timing
- done_i at cycle t is written at t and is poppable at t+1. Earliest matching done_o is at t+2 (2-cycle min latency).
- Start at cycle s: first done_o at s+2. A frame with no stalls completes with the last done_o at s+1+ROWS*COLS, and progress_done at the cycle after it.
- Stalls in ROW_M extend the frame by exactly the number of stall cycles.
- Simultaneous push and pop on a non-empty FIFO: both occur; occupancy unchanged.
- Simultaneous push and pop on a full FIFO: the push is still rejected and overflow_o is set. Pop-before-push is not credited.
- rst mid-frame: next cycle is in reset state with FIFO emptied and done_o=0. The partial frame is abandoned.

## Test plan
- COLS=ROWS=16, start_i, then 16 interior pixels 1..16 fed back-to-back once the FSM is in ROW_M of row 6 -> exactly 256 done_o pulses; 240 carry PAD_VALUE; interior raster positions (6..9, 6..9) carry 1..16 in order; progress_done pulses once, one cycle after the 256th pulse.
- Same frame, interior pixels fed with 3-cycle gaps -> done_o drops during ROW_M stalls; pixel order and count unchanged; frame length grows by the stall count.
- Interior pixels pre-loaded during TOP (16 pushed, FIFO_DEPTH=16) -> no overflow_o; interior data intact.
- 17 pushes while FIFO holds 16 and FSM is in TOP -> overflow_o=1 from the next cycle, stays 1 through DONE, clears on the next accepted start_i; 17th pixel absent from output.
- rst asserted at output pixel 100 -> done_o=0 the following cycle, no progress_done; a new start_i produces a clean 256-pixel frame.
- start_i pulsed mid-frame, and done_i pulsed in IDLE -> both ignored; frame count and content unchanged.

Source files
------------

// File: rtl/window_13x13_border_restorer.sv
// -----------------------------------------------------------------------------
// window_13x13_border_restorer
//
// Sink-side companion to the 13x13 window buffer. Upstream delivers only the
// interior pixels of a frame: (COLS-12)x(ROWS-12) valid pulses with gaps at
// row ends and no backpressure. This block rebuilds the full COLS x ROWS
// raster, one pixel per cycle, inserting PAD_VALUE on the 6-pixel border so
// that the frame writer downstream always sees full-size frames.
//
// Interior pixels are buffered in a small FIFO. The raster walk is driven by
// an FSM. The FSM stalls only in the interior span of a row (ROW_M), and only
// while the FIFO is empty.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   start_i        frame-start pulse, honoured only in IDLE
//   done_i         upstream interior pixel valid
//   data_i         upstream interior pixel
//   data_o         output pixel (registered, holds when done_o=0)
//   done_o         output pixel valid (registered)
//   progress_done  one-cycle pulse the cycle after the last frame pixel
//   overflow_o     sticky: an interior pixel arrived while the FIFO was full
// -----------------------------------------------------------------------------
module window_13x13_border_restorer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    COLS       = 640,
  parameter int                    ROWS       = 480,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int                    FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  done_o,
  output logic                  progress_done,
  output logic                  overflow_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Raster landmarks on which the FSM changes region
  localparam logic [CW-1:0] C_LEFT_LAST  = CW'(5);
  localparam logic [CW-1:0] C_MID_LAST   = CW'(COLS - 7);
  localparam logic [CW-1:0] C_LAST       = CW'(COLS - 1);
  localparam logic [RW-1:0] R_TOP_LAST   = RW'(5);
  localparam logic [RW-1:0] R_MID_LAST   = RW'(ROWS - 7);
  localparam logic [RW-1:0] R_LAST       = RW'(ROWS - 1);
  localparam logic [AW:0]   FIFO_FULL_CT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TOP    = 3'd1,
    S_ROW_L  = 3'd2,
    S_ROW_M  = 3'd3,
    S_ROW_R  = 3'd4,
    S_BOT    = 3'd5,
    S_FINISH = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_progress;
  logic                  r_overflow;

  logic                  w_issue;
  logic                  w_pad;
  logic                  w_clear;
  logic                  w_flush;
  logic                  w_accept;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_col_last;
  logic                  w_row_last;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == FIFO_FULL_CT);
  assign w_col_last   = (r_col == C_LAST);
  assign w_row_last   = (r_row == R_LAST);

  // Upstream pixels are only meaningful while a frame is being rebuilt.
  assign w_accept = (r_state != S_IDLE) && (r_state != S_FINISH) &&
                    (r_state != S_DONE);

  // Fullness is judged on the current occupancy, so a pop in the same cycle
  // does not make room for a push.
  assign w_push  = done_i && w_accept && !w_fifo_full;
  assign w_drop  = done_i && w_accept && w_fifo_full;
  assign w_pop   = w_issue && !w_pad;
  assign w_flush = (r_state == S_FINISH);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, issue and pad-select decode
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_pad        = 1'b1;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = S_TOP;
          w_clear      = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_TOP: begin
        w_issue = 1'b1;
        if ((r_row == R_TOP_LAST) && w_col_last) begin
          w_next_state = S_ROW_L;
        end else begin
          w_next_state = S_TOP;
        end
      end
      S_ROW_L: begin
        w_issue = 1'b1;
        if (r_col == C_LEFT_LAST) begin
          w_next_state = S_ROW_M;
        end else begin
          w_next_state = S_ROW_L;
        end
      end
      S_ROW_M: begin
        // Interior span: emit FIFO data, stall while it is empty.
        w_pad   = 1'b0;
        w_issue = !w_fifo_empty;
        if (!w_fifo_empty && (r_col == C_MID_LAST)) begin
          w_next_state = S_ROW_R;
        end else begin
          w_next_state = S_ROW_M;
        end
      end
      S_ROW_R: begin
        w_issue = 1'b1;
        if (w_col_last) begin
          if (r_row == R_MID_LAST) begin
            w_next_state = S_BOT;
          end else begin
            w_next_state = S_ROW_L;
          end
        end else begin
          w_next_state = S_ROW_R;
        end
      end
      S_BOT: begin
        w_issue = 1'b1;
        if (w_row_last && w_col_last) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_BOT;
        end
      end
      S_FINISH: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Raster position: advances only on cycles that issue a pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_issue) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
        r_row <= r_row;
      end
    end else begin
      r_col <= r_col;
      r_row <= r_row;
    end
  end

  // FIFO storage array (data only, occupancy is tracked separately)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // FIFO pointers and occupancy; flushed on reset and at end of frame
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag, cleared only when a new frame is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Output registers: pixel issued this cycle appears next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_done     <= 1'b0;
      r_progress <= 1'b0;
    end else begin
      r_done     <= w_issue;
      r_progress <= (r_state == S_FINISH);
      if (w_issue) begin
        r_data <= w_pad ? PAD_VALUE : r_mem[r_rd_ptr];
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign data_o        = r_data;
  assign done_o        = r_done;
  assign progress_done = r_progress;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_window_13x13_border_restorer.sv
// -----------------------------------------------------------------------------
// Directed bench for window_13x13_border_restorer on a 16x16 frame with a
// 16-entry FIFO and a non-zero pad value. A negedge monitor records every
// output pixel with its cycle number; the directed steps then compare frame
// content and timing against hand-derived values.
// -----------------------------------------------------------------------------
module tb_window_13x13_border_restorer;

  localparam int         COLS = 16;
  localparam int         ROWS = 16;
  localparam int         NPIX = COLS * ROWS;
  localparam logic [7:0] PAD  = 8'hEE;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       done_o;
  logic       progress_done;
  logic       overflow_o;

  int         cyc      = 0;
  int         n_out    = 0;
  int         n_prog   = 0;
  int         prog_cyc = 0;
  logic [7:0] out_data [0:4095];
  int         out_cyc  [0:4095];

  int         n_assert = 0;
  int         n_fail   = 0;

  window_13x13_border_restorer #(
    .DATA_WIDTH (8),
    .COLS       (COLS),
    .ROWS       (ROWS),
    .PAD_VALUE  (PAD),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .done_i        (done_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .done_o        (done_o),
    .progress_done (progress_done),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  // Cycle counter, value after each rising edge names the current cycle
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder
  always @(negedge clk) begin
    if (done_o && n_out < 4096) begin
      out_data[n_out] <= data_o;
      out_cyc[n_out]  <= cyc;
      n_out           <= n_out + 1;
    end
    if (progress_done) begin
      n_prog   <= n_prog + 1;
      prog_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic start_frame(output int s);
    start_i = 1'b1;
    s = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic push_px(input logic [7:0] v);
    done_i = 1'b1;
    data_i = v;
    tick();
    done_i = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int bp);
    int k;
    k = 0;
    while (n_prog == bp && k < 3000) begin
      tick();
      k++;
    end
    chk({tag, "_end_timeout"}, 32'(n_prog != bp), 32'd1);
    repeat (3) tick();
  endtask

  // Compare a recorded frame: count, raster content, first/last/progress timing
  task automatic check_frame(input string tag, input int bo, input int bp,
                             input int s, input int v0, input int stalls);
    int         bad;
    int         first_bad;
    int         r;
    int         c;
    logic [7:0] e;
    bad       = 0;
    first_bad = -1;
    chk({tag, "_count"}, 32'(n_out - bo), 32'(NPIX));
    chk({tag, "_prog_pulses"}, 32'(n_prog - bp), 32'd1);
    for (int i = 0; i < NPIX; i++) begin
      r = i / COLS;
      c = i % COLS;
      if (r >= 6 && r <= 9 && c >= 6 && c <= 9) e = 8'(v0 + (r - 6) * 4 + (c - 6));
      else e = PAD;
      if (out_data[bo + i] !== e) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk({tag, "_bad_pixels"}, 32'(bad), 32'd0);
    chk({tag, "_first_bad_idx"}, 32'(first_bad), 32'hFFFF_FFFF);
    chk({tag, "_first_cyc"}, 32'(out_cyc[bo] - s), 32'd2);
    chk({tag, "_last_cyc"}, 32'(out_cyc[bo + NPIX - 1] - s), 32'(NPIX + 1 + stalls));
    chk({tag, "_prog_cyc"}, 32'(prog_cyc - s), 32'(NPIX + 2 + stalls));
  endtask

  initial begin
    int s;
    int bo;
    int bp;

    rst     = 1'b1;
    start_i = 1'b0;
    done_i  = 1'b0;
    data_i  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_data_o", 32'(data_o), 32'h0);
    chk("rst_done_o", 32'(done_o), 32'h0);
    chk("rst_progress", 32'(progress_done), 32'h0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);

    // Interior fed back-to-back from the first interior slot: one stall cycle.
    // A start_i pulse in the bottom border must be ignored.
    bo = n_out; bp = n_prog;
    start_frame(s);
    wait_cyc(s + 103);
    for (int j = 1; j <= 16; j++) push_px(8'(j));
    wait_cyc(s + 200);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_frame("b2b", bp);
    check_frame("b2b", bo, bp, s, 1, 1);
    chk("b2b_interior0_cyc", 32'(out_cyc[bo + 102] - s), 32'd105);

    // done_i while IDLE must not enter the FIFO
    push_px(8'h77);
    repeat (2) tick();

    // Interior fed with 3-cycle gaps: row 6 stalls 1+3+3+3 = 10 cycles
    bo = n_out; bp = n_prog;
    start_frame(s);
    wait_cyc(s + 103);
    for (int j = 1; j <= 16; j++) begin
      push_px(8'(j));
      if (j < 16) repeat (3) tick();
    end
    wait_frame("gap", bp);
    check_frame("gap", bo, bp, s, 1, 10);
    chk("gap_interior0_cyc", 32'(out_cyc[bo + 102] - s), 32'd105);
    chk("gap_interior1_cyc", 32'(out_cyc[bo + 103] - s), 32'd109);

    // 17 pushes during TOP: 17th dropped, overflow sticky until next start
    bo = n_out; bp = n_prog;
    start_frame(s);
    for (int j = 1; j <= 16; j++) push_px(8'(j + 16));
    chk("ovf_before_17th", 32'(overflow_o), 32'h0);
    push_px(8'hF0);
    chk("ovf_after_17th", 32'(overflow_o), 32'h1);
    wait_frame("ovf", bp);
    check_frame("ovf", bo, bp, s, 17, 0);
    chk("ovf_sticky_after_frame", 32'(overflow_o), 32'h1);

    // 16 pushes during TOP into a 16-deep FIFO: no overflow, no stalls
    bo = n_out; bp = n_prog;
    start_frame(s);
    chk("pre_ovf_cleared_by_start", 32'(overflow_o), 32'h0);
    for (int j = 1; j <= 16; j++) push_px(8'(j + 32));
    chk("pre_no_overflow", 32'(overflow_o), 32'h0);
    wait_frame("pre", bp);
    check_frame("pre", bo, bp, s, 33, 0);
    chk("pre_no_overflow_end", 32'(overflow_o), 32'h0);

    // Reset while output pixel 100 is on the bus; FIFO still holds 16 pixels
    bo = n_out; bp = n_prog;
    start_frame(s);
    for (int j = 1; j <= 16; j++) push_px(8'(j + 64));
    wait_cyc(s + 102);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_done_o", 32'(done_o), 32'h0);
    chk("mrst_progress", 32'(progress_done), 32'h0);
    chk("mrst_pixels_seen", 32'(n_out - bo), 32'd101);
    repeat (300) tick();
    chk("mrst_no_more_pixels", 32'(n_out - bo), 32'd101);
    chk("mrst_no_progress", 32'(n_prog - bp), 32'd0);

    // Clean frame after the abandoned one: stale FIFO content must be gone
    bo = n_out; bp = n_prog;
    start_frame(s);
    for (int j = 1; j <= 16; j++) push_px(8'(j + 96));
    wait_frame("post", bp);
    check_frame("post", bo, bp, s, 97, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
